// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the mspu core.
// Optional perf counters are enabled by defining EXEC_SEQ_PERF_COUNTERS_EN.
module exec_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        pc_load,
  input  logic [31:0] start_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        decode_en,
  output logic        exec_en,
  input  logic        alu_unknown_op,
  input  logic [31:0] addr_out,
  input  logic        addr_out_en,
  input  logic        mem_re,
  input  logic        mem_we,
  output logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        reg_we_in,
  output logic        wb_en,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state,
  output logic [31:0] retired_count,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_TRAP    = 3'd6,
    ST_ILLEGAL = 3'd7
  } state_e;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_UNKNOWN   = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b10;
  localparam logic [1:0] CAUSE_RE_AND_WE = 2'b11;

  state_e      cur_state, nxt_state;
  logic [1:0]  cause_q, cause_nxt;
  logic [31:0] pc_q, next_pc_q;

  // NOTE: every variable assigned in always_comb gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    nxt_state = cur_state;
    cause_nxt = cause_q;
    case (cur_state)
      ST_IDLE: begin
        if (!pc_load && run) begin
          nxt_state = ST_FETCH;
          cause_nxt = CAUSE_NONE;
        end
      end
      ST_FETCH:  if (imem_ready) nxt_state = ST_DECODE;
      ST_DECODE: nxt_state = ST_EXEC;
      ST_EXEC: begin
        if (alu_unknown_op) begin
          nxt_state = ST_TRAP;
          cause_nxt = CAUSE_UNKNOWN;
        end else if (addr_out_en && (addr_out[1:0] != 2'b00)) begin
          nxt_state = ST_TRAP;
          cause_nxt = CAUSE_MISALIGN;
        end else if (mem_re && mem_we) begin
          nxt_state = ST_TRAP;
          cause_nxt = CAUSE_RE_AND_WE;
        end else if (mem_re || mem_we) begin
          nxt_state = ST_MEM;
        end else begin
          nxt_state = ST_WB;
        end
      end
      ST_MEM: if (dmem_ready) nxt_state = ST_WB;
      ST_WB:  nxt_state = run ? ST_FETCH : ST_IDLE;
      ST_TRAP: begin
        if (pc_load) begin
          nxt_state = ST_IDLE;
          cause_nxt = CAUSE_NONE;
        end
      end
      default: nxt_state = ST_TRAP;  // unreachable encoding; keep the recorded cause
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
    end else begin
      cur_state <= nxt_state;
      cause_q   <= cause_nxt;
    end
  end

  // pc only moves on a load in IDLE/TRAP or when the instruction retires in WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      next_pc_q <= '0;
    end else begin
      case (cur_state)
        ST_IDLE, ST_TRAP: if (pc_load) pc_q <= start_pc;
        ST_EXEC:          next_pc_q <= addr_out_en ? addr_out : pc_q + 32'd4;
        ST_WB:            pc_q <= next_pc_q;
        default:          ;
      endcase
    end
  end

  assign imem_req   = (cur_state == ST_FETCH);
  assign imem_addr  = pc_q;
  assign decode_en  = (cur_state == ST_DECODE);
  assign exec_en    = (cur_state == ST_EXEC);
  assign dmem_req   = (cur_state == ST_MEM);
  assign wb_en      = (cur_state == ST_WB) && reg_we_in;
  assign pc         = pc_q;
  assign busy       = (cur_state != ST_IDLE) && (cur_state != ST_TRAP);
  assign halted     = (cur_state == ST_TRAP);
  assign trap_cause = cause_q;
  assign state      = cur_state;

`ifdef EXEC_SEQ_PERF_COUNTERS_EN
  logic [31:0] retired_q, cycle_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (cur_state == ST_WB) retired_q <= retired_q + 32'd1;
      if (busy)               cycle_q   <= cycle_q + 32'd1;
    end
  end

  assign retired_count = retired_q;
  assign cycle_count   = cycle_q;
`else
  assign retired_count = '0;
  assign cycle_count   = '0;
`endif

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control FSM for the mspu core that drives the executer and its neighbouring stages through fetch, decode, execute, memory and writeback. It owns the architectural PC and sequences the instruction-memory and data-memory request/ready handshakes. It selects the next PC from the executer's branch/jump target and traps on illegal ops or misaligned targets. It sits between the core top level and the stage datapaths; the stages see only one-cycle enables.

## Interface
- No parameters.
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; allows instruction issue from IDLE and continuation after WB
- pc_load  in  1  pulse; in IDLE or TRAP loads start_pc into pc
- start_pc  in  32  PC loaded by pc_load
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  fetch data valid/accepted this cycle
- decode_en  out  1  decoder capture enable
- exec_en  out  1  executer operand/result valid strobe
- alu_unknown_op  in  1  from executer; sampled in EXEC
- addr_out  in  32  branch/jump target from executer
- addr_out_en  in  1  target taken; sampled in EXEC
- mem_re  in  1  executer re_out; sampled in EXEC
- mem_we  in  1  executer we_out; sampled in EXEC
- dmem_req  out  1  data memory request
- dmem_ready  in  1  data access complete this cycle
- reg_we_in  in  1  executer reg_we_out
- wb_en  out  1  register-file write strobe
- pc  out  32  PC of the instruction in flight
- busy  out  1  state not IDLE and not TRAP
- halted  out  1  state == TRAP
- trap_cause  out  2  01 unknown op, 10 misaligned target, 11 re and we both set
- state  out  3  debug encoding of current state
- retired_count  out  32  retired instructions (macro-gated)
- cycle_count  out  32  busy cycles (macro-gated)

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Outputs are Moore, decoded from the state register.
- IDLE:
  - pc_load=1 → pc←start_pc, stay IDLE.
  - Otherwise run=1 → FETCH.
  - If both occur in the same cycle, the load wins and FETCH follows next cycle if run is still 1.
- FETCH: imem_req=1, imem_addr=pc. Held until imem_ready=1, then → DECODE. Ready in the same cycle as the request is accepted.
- DECODE: decode_en=1 for exactly one cycle, then → EXEC.
- EXEC: exec_en=1 for exactly one cycle. next_pc register ← addr_out_en ? addr_out : pc+4, with 32-bit wrap (0xFFFFFFFC+4 = 0). Transition priority:
  1. alu_unknown_op → TRAP, cause 01.
  2. addr_out_en and addr_out[1:0]≠0 → TRAP, cause 10.
  3. mem_re and mem_we → TRAP, cause 11.
  4. mem_re or mem_we → MEM.
  5. Otherwise → WB.
- MEM: dmem_req=1 until dmem_ready=1, then → WB.
- WB: wb_en=reg_we_in for one cycle. pc←next_pc, retired_count+1. Then → FETCH if run=1, else IDLE.
- run=0 mid-instruction does not abort; the instruction completes through WB, then → IDLE.
- TRAP: pc holds the faulting instruction's PC and trap_cause holds its code. pc_load → pc←start_pc, trap_cause←0, → IDLE. Only reset or pc_load exits TRAP.
- trap_cause is cleared on leaving IDLE for FETCH.
- The 3'b111 encoding is unreachable; if entered, the FSM goes to TRAP with trap_cause unchanged.

## Timing
- Reset (async assert, sync release):
  - state=IDLE; pc, next_pc, trap_cause and both counters = 0.
  - All request, enable and strobe outputs = 0.
- Zero-wait-state instruction latency:
  - ALU or branch instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
  - Each imem/dmem wait cycle adds one cycle.
- pc updates on the clock edge leaving WB; the next FETCH presents the new imem_addr in its first cycle.
- exec_en, decode_en and wb_en are single-cycle pulses, never asserted back-to-back.
- imem_req and dmem_req never overlap.
- cycle_count increments every cycle that busy=1.
- Reset asserted mid-instruction returns to IDLE immediately; no wb_en and no retire.

## Configuration
- EXEC_SEQ_PERF_COUNTERS_EN defined: retired_count and cycle_count are implemented as free-running 32-bit counters that wrap at 2^32.
- Not defined: both outputs are tied to 0 and no counter registers are built.

## Test plan
- ADD-type instruction at start_pc=0x100, zero-wait memories, run=1: pc_load, then after 4 busy cycles exactly one wb_en=1 pulse; pc=0x104; retired_count=1.
- Taken branch: addr_out=0x200, addr_out_en=1 in EXEC → next imem_addr=0x200. Same with addr_out=0x202 → TRAP, trap_cause=10, pc unchanged, no wb_en.
- Load with dmem_ready delayed 3 cycles: dmem_req high for 4 cycles; instruction takes 8 cycles total; wb_en follows ready by one cycle.
- alu_unknown_op=1 in EXEC → halted=1, trap_cause=01, busy=0. pc_load with start_pc=0x0 → IDLE, trap_cause=0.
- run dropped during a FETCH stalled by imem_ready: instruction completes WB, then IDLE. pc=old+4; no further imem_req.
- Reset pulsed while in MEM: state=0 and all outputs 0 asynchronously. With the macro defined, counters=0. pc=0xFFFFFFFC ALU instruction → pc wraps to 0x0.
